// File: rtl/pic_pkg.sv
// Shared types and constants for the parametrised interrupt controller.
package pic_pkg;

  typedef enum logic [2:0] {
    InitWait,
    InitIcw2,
    InitIcw3,
    InitIcw4,
    InitReady
  } init_state_e;

  typedef enum logic [0:0] {
    AckIdle,
    AckWait2
  } ack_state_e;

  // OCW2 command codes on din[7:5]
  localparam logic [2:0] Ocw2NsEoi    = 3'b001;
  localparam logic [2:0] Ocw2SpEoi    = 3'b011;
  localparam logic [2:0] Ocw2RotNsEoi = 3'b101;
  localparam logic [2:0] Ocw2SetPrio  = 3'b110;

  // ICW bit positions
  localparam int unsigned Icw1Ic4Bit  = 0;
  localparam int unsigned Icw1SnglBit = 1;
  localparam int unsigned Icw1LtimBit = 3;
  localparam int unsigned Icw4AeoiBit = 1;

  // OCW3 read-select codes on din[1:0]
  localparam logic [1:0] Ocw3RdIrr = 2'b10;
  localparam logic [1:0] Ocw3RdIsr = 2'b11;

endpackage

// File: rtl/pic_rot_resolver.sv
// Rotating find-first: picks the highest-priority set bit of req, where the
// highest priority is prio_low+1 (mod NUM_IRQ), descending cyclically.
module pic_rot_resolver #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req_i,
  input  logic [ID_W-1:0]    prio_low_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx     = '0;
    valid_o = 1'b0;
    id_o    = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = prio_low_i + ID_W'(k + 1);
      if (req_i[idx]) begin
        valid_o = 1'b1;
        id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/pic_ctrl_param.sv
// Interrupt-controller core: ICW sequencer, OCW decode, IRR/ISR/IMR,
// fully nested rotating priority and the two-pulse INTA vector sequencer.
module pic_ctrl_param
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic               a0,
  input  logic [7:0]         din,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inta,
  output logic               int_o,
  output logic [7:0]         dout,
  output logic               dout_en
);

  init_state_e         init_q, init_d;
  ack_state_e          ack_q, ack_d;
  logic                ic4_q, ic4_d, sngl_q, sngl_d, ltim_q, ltim_d, aeoi_q, aeoi_d;
  logic [7-ID_W:0]     vec_base_q, vec_base_d;
  logic [NUM_IRQ-1:0]  imr_q, imr_d, isr_q, isr_d, irr_q, irr_d, irq_q;
  logic                rd_isr_q, rd_isr_d;
  logic [ID_W-1:0]     prio_low_q, prio_low_d, ack_id_q, ack_id_d;
  logic                ack_spur_q, ack_spur_d;
  logic                int_q, int_d, dout_en_q, dout_en_d;
  logic [7:0]          dout_q, dout_d, rd_val;

  logic                cand_vld, isr_vld;
  logic [ID_W-1:0]     cand_id, isr_id, cand_rank, isr_rank;
  logic                ready, icw1_wr, ack_go, ack1, ack2, outranks;

  pic_rot_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_cand (
    .req_i      (irr_q & ~imr_q),
    .prio_low_i (prio_low_q),
    .valid_o    (cand_vld),
    .id_o       (cand_id)
  );

  pic_rot_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr (
    .req_i      (isr_q),
    .prio_low_i (prio_low_q),
    .valid_o    (isr_vld),
    .id_o       (isr_id)
  );

  // Command decode, register next-state, arbitration and output staging.
  always_comb begin
    init_d     = init_q;
    ack_d      = ack_q;
    ic4_d      = ic4_q;
    sngl_d     = sngl_q;
    ltim_d     = ltim_q;
    aeoi_d     = aeoi_q;
    vec_base_d = vec_base_q;
    imr_d      = imr_q;
    isr_d      = isr_q;
    rd_isr_d   = rd_isr_q;
    prio_low_d = prio_low_q;
    ack_id_d   = ack_id_q;
    ack_spur_d = ack_spur_q;
    dout_d     = dout_q;
    dout_en_d  = 1'b0;
    rd_val     = '0;

    ready   = (init_q == InitReady);
    icw1_wr = wr_en & ~a0 & din[4];
    ack_go  = inta & ready & ~icw1_wr;  // ICW1 beats a coincident inta
    ack1    = ack_go & (ack_q == AckIdle);
    ack2    = ack_go & (ack_q == AckWait2);

    // Rank 0 is the highest priority under the current rotation.
    cand_rank = cand_id - prio_low_q - ID_W'(1);
    isr_rank  = isr_id - prio_low_q - ID_W'(1);
    outranks  = cand_vld & (~isr_vld | (cand_rank < isr_rank));

    if (ltim_q) irr_d = irq;
    else        irr_d = irr_q | (irq & ~irq_q);

    if (icw1_wr) begin
      init_d     = InitIcw2;
      ack_d      = AckIdle;
      ic4_d      = din[Icw1Ic4Bit];
      sngl_d     = din[Icw1SnglBit];
      ltim_d     = din[Icw1LtimBit];
      aeoi_d     = 1'b0;  // stays 0 when ICW4 is skipped
      imr_d      = '0;
      isr_d      = '0;
      irr_d      = '0;
      rd_isr_d   = 1'b0;
      prio_low_d = ID_W'(NUM_IRQ - 1);
    end else if (wr_en && a0) begin
      case (init_q)
        InitIcw2: begin
          vec_base_d = din[7:ID_W];
          if (!sngl_q)    init_d = InitIcw3;
          else if (ic4_q) init_d = InitIcw4;
          else            init_d = InitReady;
        end
        // No cascading here: ICW3 only advances the sequencer.
        InitIcw3: init_d = ic4_q ? InitIcw4 : InitReady;
        InitIcw4: begin
          aeoi_d = din[Icw4AeoiBit];
          init_d = InitReady;
        end
        InitReady: imr_d = din[NUM_IRQ-1:0];
        default: ;
      endcase
    end else if (wr_en && ready) begin
      if (din[4:3] == 2'b00) begin
        case (din[7:5])
          Ocw2NsEoi:    if (isr_vld) isr_d[isr_id] = 1'b0;
          Ocw2SpEoi:    isr_d[din[ID_W-1:0]] = 1'b0;
          Ocw2RotNsEoi: if (isr_vld) begin
            isr_d[isr_id] = 1'b0;
            prio_low_d    = isr_id;
          end
          Ocw2SetPrio:  prio_low_d = din[ID_W-1:0];
          default: ;
        endcase
      end else if (din[4:3] == 2'b01) begin
        if (din[1:0] == Ocw3RdIrr)      rd_isr_d = 1'b0;
        else if (din[1:0] == Ocw3RdIsr) rd_isr_d = 1'b1;
      end
    end

    // Ack updates come last so INTA set beats EOI and IRR clear beats set.
    if (ack1) begin
      ack_d = AckWait2;
      if (cand_vld) begin
        ack_id_d       = cand_id;
        ack_spur_d     = 1'b0;
        isr_d[cand_id] = 1'b1;
        if (!ltim_q) irr_d[cand_id] = 1'b0;
      end else begin
        ack_id_d   = ID_W'(NUM_IRQ - 1);
        ack_spur_d = 1'b1;
      end
    end else if (ack2) begin
      ack_d = AckIdle;
      if (aeoi_q && !ack_spur_q) isr_d[ack_id_q] = 1'b0;
    end

    if (ack2) begin
      dout_d    = {vec_base_q, ack_id_q};
      dout_en_d = 1'b1;
    end else if (rd_en) begin
      rd_val[NUM_IRQ-1:0] = a0 ? imr_q : (rd_isr_q ? isr_q : irr_q);
      dout_d    = rd_val;
      dout_en_d = 1'b1;
    end

    int_d = ready & (ack_q == AckIdle) & ~ack_go & ~icw1_wr & outranks;
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q     <= InitWait;
      ack_q      <= AckIdle;
      ic4_q      <= 1'b0;
      sngl_q     <= 1'b0;
      ltim_q     <= 1'b0;
      aeoi_q     <= 1'b0;
      vec_base_q <= '0;
      imr_q      <= '0;
      isr_q      <= '0;
      irr_q      <= '0;
      irq_q      <= '0;
      rd_isr_q   <= 1'b0;
      prio_low_q <= ID_W'(NUM_IRQ - 1);
      ack_id_q   <= '0;
      ack_spur_q <= 1'b0;
      int_q      <= 1'b0;
      dout_q     <= '0;
      dout_en_q  <= 1'b0;
    end else begin
      init_q     <= init_d;
      ack_q      <= ack_d;
      ic4_q      <= ic4_d;
      sngl_q     <= sngl_d;
      ltim_q     <= ltim_d;
      aeoi_q     <= aeoi_d;
      vec_base_q <= vec_base_d;
      imr_q      <= imr_d;
      isr_q      <= isr_d;
      irr_q      <= irr_d;
      irq_q      <= irq;
      rd_isr_q   <= rd_isr_d;
      prio_low_q <= prio_low_d;
      ack_id_q   <= ack_id_d;
      ack_spur_q <= ack_spur_d;
      int_q      <= int_d;
      dout_q     <= dout_d;
      dout_en_q  <= dout_en_d;
    end
  end

  assign int_o   = int_q;
  assign dout    = dout_q;
  assign dout_en = dout_en_q;

endmodule

// File: tb/tb_pic_ctrl_param.sv
// Directed bench for pic_ctrl_param with hand-computed expected values.
module tb_pic_ctrl_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, a0 = 1'b0, inta = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] irq = 8'h00;
  logic       int_o, dout_en;
  logic [7:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  pic_ctrl_param #(.NUM_IRQ(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .a0      (a0),
    .din     (din),
    .irq     (irq),
    .inta    (inta),
    .int_o   (int_o),
    .dout    (dout),
    .dout_en (dout_en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    wr_en = 1'b1; a0 = a; din = d;
    cyc();
    wr_en = 1'b0; a0 = 1'b0; din = 8'h00;
  endtask

  task automatic rd_chk(input logic a, input logic [7:0] exp, input string tag);
    rd_en = 1'b1; a0 = a;
    cyc();
    rd_en = 1'b0; a0 = 1'b0;
    check_eq({tag, "_en"}, dout_en, 1);
    check_eq(tag, dout, exp);
  endtask

  task automatic ack(input logic [7:0] exp, input string tag);
    inta = 1'b1;
    cyc();
    inta = 1'b0;
    check_eq({tag, "_intfall"}, int_o, 0);
    inta = 1'b1;
    cyc();
    inta = 1'b0;
    check_eq({tag, "_en"}, dout_en, 1);
    check_eq({tag, "_vec"}, dout, exp);
  endtask

  task automatic init(input logic [7:0] icw4);
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h40);
    wr(1'b1, icw4);
  endtask

  initial begin
    // Reset values
    cyc(2);
    check_eq("rst_int", int_o, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_douten", dout_en, 0);
    rst = 1'b0;
    cyc();

    // Init with IC4, edge mode; basic interrupt and ack
    init(8'h00);
    irq = 8'h08;
    cyc();
    check_eq("irq3_lat1", int_o, 0);
    cyc();
    check_eq("irq3_lat2", int_o, 1);
    ack(8'h43, "ack3");
    cyc();
    check_eq("douten_1cyc", dout_en, 0);
    wr(1'b0, 8'h0A);
    rd_chk(1'b0, 8'h00, "irr_after_ack");
    wr(1'b0, 8'h0B);
    rd_chk(1'b0, 8'h08, "isr_after_ack");
    wr(1'b0, 8'h20);
    rd_chk(1'b0, 8'h00, "isr_after_eoi");

    // Fully nested priority
    irq = 8'h00; cyc();
    irq = 8'h08; cyc(2);
    check_eq("nest_int3", int_o, 1);
    ack(8'h43, "nest_ack3");
    irq = 8'h28; cyc(3);
    check_eq("nest_irq5_blocked", int_o, 0);
    irq = 8'h2A; cyc();
    check_eq("nest_irq1_lat1", int_o, 0);
    cyc();
    check_eq("nest_irq1_lat2", int_o, 1);
    ack(8'h41, "nest_ack1");
    rd_chk(1'b0, 8'h0A, "nest_isr");
    wr(1'b0, 8'h20); cyc();
    check_eq("nest_eoi1_int", int_o, 0);
    rd_chk(1'b0, 8'h08, "nest_isr_eoi1");
    wr(1'b0, 8'h20); cyc();
    check_eq("nest_eoi3_int", int_o, 1);
    ack(8'h45, "nest_ack5");
    wr(1'b0, 8'h20);
    irq = 8'h00; cyc();

    // Rotation on non-specific EOI
    irq = 8'h04; cyc(2);
    ack(8'h42, "rot_ack2");
    wr(1'b0, 8'hA0);
    rd_chk(1'b0, 8'h00, "rot_isr");
    irq = 8'h0D; cyc(2);
    check_eq("rot_int", int_o, 1);
    ack(8'h43, "rot_ack3");
    wr(1'b0, 8'h20); cyc();
    check_eq("rot_int0", int_o, 1);
    ack(8'h40, "rot_ack0");
    wr(1'b0, 8'h20);
    irq = 8'h00; cyc();

    // AEOI and masking
    init(8'h02);
    wr(1'b1, 8'hFE);
    irq = 8'h01; cyc(2);
    check_eq("aeoi_int", int_o, 1);
    ack(8'h40, "aeoi_ack0");
    wr(1'b0, 8'h0B);
    rd_chk(1'b0, 8'h00, "aeoi_isr");
    irq = 8'h03; cyc(3);
    check_eq("mask_int", int_o, 0);
    rd_chk(1'b1, 8'hFE, "imr_read");
    wr(1'b0, 8'h0A);
    rd_chk(1'b0, 8'h02, "mask_irr");

    // Spurious ack, with a read colliding with the second inta
    inta = 1'b1; cyc();
    inta = 1'b1; rd_en = 1'b1; a0 = 1'b0; cyc();
    inta = 1'b0; rd_en = 1'b0;
    check_eq("spur_en", dout_en, 1);
    check_eq("spur_vec", dout, 8'h47);
    cyc();
    check_eq("spur_en_drop", dout_en, 0);
    check_eq("spur_hold", dout, 8'h47);
    rd_chk(1'b0, 8'h02, "spur_irr");
    wr(1'b0, 8'h0B);
    rd_chk(1'b0, 8'h00, "spur_isr");

    // Reset between the two inta strobes
    irq = 8'h00; cyc();
    irq = 8'h01; cyc(2);
    check_eq("rstack_int", int_o, 1);
    inta = 1'b1; cyc(); inta = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rstack_int0", int_o, 0);
    check_eq("rstack_douten", dout_en, 0);
    check_eq("rstack_dout", dout, 0);
    cyc();
    rst = 1'b0;
    wr(1'b1, 8'hFF);
    cyc(2);
    check_eq("rstack_notready", int_o, 0);
    rd_chk(1'b1, 8'h00, "rstack_imr");

    // ICW1 between the two inta strobes
    init(8'h00);
    irq = 8'h00; cyc();
    irq = 8'h01; cyc(2);
    check_eq("icw1ack_int", int_o, 1);
    inta = 1'b1; cyc(); inta = 1'b0;
    init(8'h00);
    wr(1'b0, 8'h0B);
    rd_chk(1'b0, 8'h00, "icw1ack_isr");
    wr(1'b0, 8'h0A);
    rd_chk(1'b0, 8'h00, "icw1ack_irr");
    inta = 1'b1; cyc(); inta = 1'b0;
    check_eq("icw1ack_idle", dout_en, 0);
    inta = 1'b1; cyc(); inta = 1'b0;
    check_eq("icw1ack_spur_en", dout_en, 1);
    check_eq("icw1ack_spur_vec", dout, 8'h47);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_ctrl_param.md
# pic_ctrl_param

Parametrised, fully synchronous interrupt-controller core for N request lines: ICW initialisation sequencer, OCW command decode, request/in-service/mask registers, fully nested rotating-priority arbitration and a two-pulse INTA vector sequencer. It sits between the read/write logic and the data-bus buffer. It drives `int_o` to the CPU and returns the interrupt vector on `dout` on the second acknowledge.

## Interface
- `NUM_IRQ`, 8: number of request lines; must be 2, 4 or 8.
- `ID_W`, `$clog2(NUM_IRQ)`: width of the interrupt id; derived, never overridden.
- `clk` in 1: single clock for the whole block; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: one-cycle write strobe.
- `rd_en` in 1: one-cycle read strobe.
- `a0` in 1: register select.
- `din` in 8: write data.
- `irq` in NUM_IRQ: request lines, already synchronous to `clk`.
- `inta` in 1: one-cycle strobe, one per CPU acknowledge pulse.
- `int_o` out 1: interrupt request to CPU.
- `dout` out 8: read data or vector.
- `dout_en` out 1: high for the cycle `dout` is valid; bus buffer drives toward the CPU.

## Operation
- **Reset values:** all registers 0, init state `INIT_WAIT`, ack state `ACK_IDLE`, `prio_low = NUM_IRQ-1` (id 0 highest), `int_o = 0`, `dout = 0`, `dout_en = 0`.
- **Init FSM:**
  - States: `INIT_WAIT` → `ICW2` → `ICW3` → `ICW4` → `READY`.
  - A write with `a0=0`, `din[4]=1` is ICW1 from any state. It captures icw1, clears IMR/ISR/IRR/OCW3 select, sets `prio_low = NUM_IRQ-1`, aborts any ack sequence, and enters `ICW2`.
  - In `ICW2`, `ICW3` and `ICW4`, a write with `a0=1` captures that word. `ICW3` is skipped when icw1[1]=1 (SNGL). `ICW4` is skipped when icw1[0]=0, and icw4 is then forced to 0.
  - Writes with `a0=0`, `din[4]=0` are ignored before `READY`.
- **OCWs in READY:**
  - `a0=1`: OCW1, `IMR <= din[NUM_IRQ-1:0]`.
  - `a0=0`, `din[4:3]=00`: OCW2, decoded on `din[7:5]`:
    - 001: non-specific EOI, clears the highest-priority set ISR bit.
    - 011: specific EOI, clears `ISR[din[ID_W-1:0]]`.
    - 101: rotate on non-specific EOI, clears as for 001 and sets `prio_low` to the cleared id.
    - 110: set priority, `prio_low <= din[ID_W-1:0]`.
    - Other codes: no effect.
  - `a0=0`, `din[4:3]=01`: OCW3. `din[1:0]=10` selects IRR and `11` selects ISR for reads; other values leave the selection unchanged.
- **Reads:** `rd_en` with `a0=0` returns IRR or ISR (per OCW3); with `a0=1` it returns IMR. Values are zero-extended to 8 bits.
- **IRR:**
  - Edge mode (icw1[3]=0): a rising edge of `irq[i]` versus the previous cycle sets `IRR[i]`. The bit holds until the first INTA for id i.
  - Level mode: `IRR` is registered `irq`.
- **Priority:** highest id is `(prio_low+1) mod NUM_IRQ`, then descending cyclically. Candidate = highest-priority bit of `IRR & ~IMR`.
- **Interrupt output:** `int_o = 1` iff the FSM is `READY`, ack state is `ACK_IDLE`, and the candidate outranks every set ISR bit.
- **Ack FSM:**
  - `ACK_IDLE` --inta--> `ACK_WAIT2`: latch id = candidate, set `ISR[id]`, clear `IRR[id]` in edge mode. With no candidate (spurious), id = NUM_IRQ-1 and ISR/IRR are unchanged.
  - `ACK_WAIT2` --inta--> `ACK_IDLE`: drive vector `{icw2[7:ID_W], id}`. If icw4[1]=1 (AEOI), clear `ISR[id]` in the same edge; a spurious ack clears nothing.
- **Simultaneous events:**
  - IRR set and clear on the same bit in the same cycle: clear wins.
  - ISR set by INTA and specific EOI on the same bit in the same cycle: set wins.
  - `rd_en` in the same cycle as the second `inta`: vector wins, the read is dropped.
  - ICW1 in the same cycle as `inta`: ICW1 wins, the `inta` is ignored.
  - `inta` before `READY`: ignored.

## Timing
- `int_o` is registered and updates one cycle after the causing IRR/IMR/ISR change, so it rises 2 cycles after an `irq` rising edge.
- `int_o` falls the cycle after the first `inta`.
- Read data: `dout`/`dout_en` are valid exactly one cycle after `rd_en`, with `dout_en` high for that one cycle only.
- Vector: `dout`/`dout_en` are valid one cycle after the second `inta`.
- `dout` holds its last value while `dout_en = 0`.
- Register writes take effect on the `wr_en` edge and are visible to arbitration in the next cycle.
- Reset asserted mid-sequence returns every output to its reset value immediately (asynchronous).

## Structure
- Package `pic_pkg`:
  - init and ack state enums;
  - OCW2 command codes (3'b001, 3'b011, 3'b101, 3'b110);
  - ICW bit-position constants (IC4=0, SNGL=1, LTIM=3, AEOI=1);
  - OCW3 read-select codes.
- Sub-module `pic_rot_resolver`: combinational rotating find-first. Inputs are a request vector and `prio_low`; outputs are valid and id. It is instantiated twice: once for the candidate and once for the highest ISR bit (used by non-specific EOI and nesting).

## Test plan
- **Init with IC4, edge mode:** ICW1 0x13, ICW2 0x40, ICW4 0x00; then irq[3] rises → `int_o=1` after 2 cycles. Two `inta` strobes → vector 0x43 and `ISR=0x08`. OCW2 0x20 → `ISR=0x00`.
- **Fully nested priority:** with ISR[3] set, irq[5] rises → `int_o` stays 0. Then irq[1] rises → `int_o=1`, and the ack returns 0x41.
- **Rotation:** ISR[2] set, OCW2 0xA0 → `ISR=0`, `prio_low=2`. Pending 0x09 (ids 0 and 3) → vector 0x43 (id 3 ranks above id 0).
- **AEOI and masking:** ICW4 0x02, OCW1 0xFE. irq[0] rises → vector 0x40 with ISR 0x00 after the second ack. irq[1] rises → `int_o` stays 0.
- **Spurious ack and reads:** `inta` with no pending request → vector 0x47 (`NUM_IRQ=8`) and ISR unchanged. OCW3 0x0B then `rd_en`, `a0=0` → `dout` = ISR one cycle later with `dout_en=1`.
- **Reset and re-init mid-ack:** assert `rst` between the two `inta` strobes → `int_o=0`, `dout_en=0`, state `INIT_WAIT`. Repeat with ICW1 instead of `rst` → ack state `ACK_IDLE` and IRR/ISR cleared.
